// File: rtl/binary_multiplier_unit_if.sv
// Handshake and operand/product bundle for the iterative unsigned multiplier.
// The requester drives start/A/B and observes P/busy/done.
interface binary_multiplier_unit_if #(
  parameter int unsigned N = 24
);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;

  modport master (
    output start, A, B,
    input  P, busy, done
  );

  modport slave (
    input  start, A, B,
    output P, busy, done
  );
endinterface

// File: rtl/binary_multiplier_unit.sv
// Unsigned N x N -> 2N shift-and-add multiplier: one adder, N RUN cycles per product,
// start/busy/done handshake, product register updated only on completion.
module binary_multiplier_unit #(
  parameter int unsigned N = 24
) (
  input logic                     clk,
  input logic                     rst_n,
  binary_multiplier_unit_if.slave bus
);

  localparam int unsigned W    = 2 * N;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    p_q, p_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_sum;
  logic            last_iter;

  // Single adder: conditionally add the shifted multiplicand this iteration.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == CntW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = {{N{1'b0}}, bus.A};
          mplier_d = bus.B;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // P takes the completed sum in one step, never a partial value.
        if (last_iter) p_d = acc_sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
    bus.P    = p_q;
  end

endmodule

// File: tb/tb_binary_multiplier_unit.sv
// Directed bench for binary_multiplier_unit: vector table plus hand-written sequences for
// start-during-run, asynchronous abort and back-to-back operation.
module tb_binary_multiplier_unit;

  localparam int unsigned N = 24;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;

  binary_multiplier_unit_if #(.N(N)) bus ();

  binary_multiplier_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT in IDLE; returns the same way, one cycle after done.
  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input string name);
    int n;
    int busy_n;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n      = 0;
    busy_n = 0;
    while (!bus.done && n < N + 6) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      n++;
    end
    check({name, " done_seen"}, 64'(bus.done), 64'd1);
    check({name, " latency"}, 64'(n), 64'(N));
    check({name, " busy_cycles"}, 64'(busy_n), 64'(N));
    check({name, " P"}, 64'(bus.P), 64'(exp));
    @(posedge clk); #1;
    check({name, " done_pulse_len"}, 64'(bus.done), 64'd0);
    check({name, " P_hold"}, 64'(bus.P), 64'(exp));
  endtask

  vec_t           vecs[10];
  logic [N-1:0]   bb_a[3];
  logic [N-1:0]   bb_b[3];

  initial begin
    int n;
    int done_cnt;
    int prev_cyc;
    logic [2*N-1:0] model;

    errors = 0;
    checks = 0;

    vecs[0] = '{a: 24'd5,       b: 24'd2,       p: 48'd10};
    vecs[1] = '{a: 24'hFFFFF7,  b: 24'd3,       p: 48'd50331621};
    vecs[2] = '{a: 24'd11,      b: 24'd4,       p: 48'd44};
    vecs[3] = '{a: 24'hFFFFFB,  b: 24'hFFFFF9,  p: 48'hFFFFF4000023};
    vecs[4] = '{a: 24'hFFFFFF,  b: 24'hFFFFFF,  p: 48'hFFFFFE000001};
    vecs[5] = '{a: 24'd0,       b: 24'h123456,  p: 48'd0};
    vecs[6] = '{a: 24'h123456,  b: 24'd0,       p: 48'd0};
    vecs[7] = '{a: 24'd1,       b: 24'hFFFFFF,  p: 48'h000000FFFFFF};
    vecs[8] = '{a: 24'h800000,  b: 24'h800000,  p: 48'h400000000000};
    vecs[9] = '{a: 24'd1000,    b: 24'd1000,    p: 48'd1000000};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check("reset P", 64'(bus.P), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // start and operand changes during RUN must be ignored
    bus.A     = 24'd100;
    bus.B     = 24'd200;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.A     = 24'd7;
    bus.B     = 24'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = 24'hABCDEF;
    bus.B     = 24'h654321;
    n        = 0;
    done_cnt = 0;
    while (!bus.done && n < N + 6) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore done_seen", 64'(bus.done), 64'd1);
    check("ignore P", 64'(bus.P), 64'd20000);
    repeat (N + 4) begin
      if (bus.done) done_cnt++;
      @(posedge clk); #1;
    end
    check("ignore done_count", 64'(done_cnt), 64'd1);
    check("ignore P_hold", 64'(bus.P), 64'd20000);

    // Asynchronous abort in the middle of RUN
    bus.A     = 24'd1234;
    bus.B     = 24'd5678;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("abort pre busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort P", 64'(bus.P), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    #3 rst_n = 1'b1;
    done_cnt = 0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_cnt++;
    end
    check("abort stays idle", 64'(done_cnt), 64'd0);
    do_mul(24'd9, 24'd3, 48'd27, "post_abort");

    // Back-to-back with start held high
    bb_a[0] = 24'd3;      bb_b[0] = 24'd5;
    bb_a[1] = 24'hFFFFFF; bb_b[1] = 24'd2;
    bb_a[2] = 24'h012345; bb_b[2] = 24'h00ABCD;
    bus.A     = bb_a[0];
    bus.B     = bb_b[0];
    bus.start = 1'b1;
    prev_cyc  = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!bus.done && n < N + 8);
      model = (2 * N)'(bb_a[k]) * (2 * N)'(bb_b[k]);
      check($sformatf("b2b%0d done_seen", k), 64'(bus.done), 64'd1);
      check($sformatf("b2b%0d P", k), 64'(bus.P), 64'(model));
      if (k > 0) check($sformatf("b2b%0d spacing", k), 64'(cyc - prev_cyc), 64'(N + 2));
      prev_cyc = cyc;
      if (k < 2) begin
        bus.A = bb_a[k + 1];
        bus.B = bb_b[k + 1];
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    check("b2b idle busy", 64'(bus.busy), 64'd0);
    check("b2b P_hold", 64'(bus.P), 64'((2 * N)'(bb_a[2]) * (2 * N)'(bb_b[2])));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
